// File: rtl/spi_mem_arbiter.sv
// Two-port arbiter in front of a SPI ROM and a SPI RAM sharing one bus.
// Each granted request becomes one 40-bit mode-0 frame:
// opcode, address high byte, address[15:8], address[7:0], data byte.
// The last 8 bits of a read shift the returned byte in on miso.
module spi_mem_arbiter #(
  parameter logic [7:0] RD_CMD  = 8'h03,
  parameter logic [7:0] WR_CMD  = 8'h02,
  parameter logic [7:0] ADDR_HI = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        ram0,
  input  logic        ram1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        done0,
  output logic        done1,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_rom_n,
  output logic        cs_ram_n
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;          // 1 = port 1 has priority on a tie
  logic        port_q, port_d;        // port owning the current frame
  logic        we_q, we_d;
  logic [6:0]  cnt_q, cnt_d;          // half-bit counter, 0..79
  logic [39:0] sh_q, sh_d;            // outgoing frame, MSB next
  logic [7:0]  rx_q, rx_d;            // incoming read byte
  logic [7:0]  rdata_q, rdata_d;
  logic        done0_q, done0_d, done1_q, done1_d, busy_q, busy_d;
  logic        sclk_q, sclk_d, mosi_q, mosi_d;
  logic        cs_rom_n_q, cs_rom_n_d, cs_ram_n_q, cs_ram_n_d;

  logic        gnt_port, sel_we, sel_ram;
  logic [15:0] sel_addr;
  logic [7:0]  sel_wdata;
  logic [39:0] frame;

  // Round-robin pick and the frame that port would send.
  always_comb begin
    gnt_port  = (req0 && req1) ? ptr_q : req1;
    sel_we    = gnt_port ? we1    : we0;
    sel_ram   = gnt_port ? ram1   : ram0;
    sel_addr  = gnt_port ? addr1  : addr0;
    sel_wdata = gnt_port ? wdata1 : wdata0;
    frame     = {(sel_we ? WR_CMD : RD_CMD), ADDR_HI, sel_addr,
                 (sel_we ? sel_wdata : 8'h00)};
  end

  // Next-state and registered-output logic for IDLE / SHIFT / DONE.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    port_d     = port_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    rx_d       = rx_q;
    rdata_d    = rdata_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    busy_d     = busy_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_rom_n_d = cs_rom_n_q;
    cs_ram_n_d = cs_ram_n_q;
    case (state_q)
      IDLE: begin
        busy_d     = 1'b0;
        sclk_d     = 1'b0;
        mosi_d     = 1'b0;
        cs_rom_n_d = 1'b1;
        cs_ram_n_d = 1'b1;
        if (req0 || req1) begin
          ptr_d  = ~gnt_port;
          port_d = gnt_port;
          we_d   = sel_we;
          busy_d = 1'b1;
          if (sel_we && !sel_ram) begin
            // ROM cannot be written: acknowledge without touching the bus.
            state_d = DONE;
            done0_d = ~gnt_port;
            done1_d = gnt_port;
          end else begin
            state_d    = SHIFT;
            sh_d       = frame;
            mosi_d     = frame[39];
            cnt_d      = 7'd0;
            cs_ram_n_d = ~sel_ram;
            cs_rom_n_d = sel_ram;
          end
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + 7'd1;
        if (!cnt_q[0]) begin
          sclk_d = 1'b1;
        end else begin
          // End of the high phase: sample, then advance to the next bit.
          if (cnt_q >= 7'd65) rx_d = {rx_q[6:0], miso};
          sclk_d = 1'b0;
          if (cnt_q == 7'd79) begin
            state_d    = DONE;
            mosi_d     = 1'b0;
            cs_rom_n_d = 1'b1;
            cs_ram_n_d = 1'b1;
            done0_d    = ~port_q;
            done1_d    = port_q;
            if (!we_q) rdata_d = {rx_q[6:0], miso};
          end else begin
            mosi_d = sh_q[38];
            sh_d   = {sh_q[38:0], 1'b0};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= 7'd0;
      sh_q       <= 40'd0;
      rx_q       <= 8'h00;
      rdata_q    <= 8'h00;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_rom_n_q <= 1'b1;
      cs_ram_n_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      port_q     <= port_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      rx_q       <= rx_d;
      rdata_q    <= rdata_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      busy_q     <= busy_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_rom_n_q <= cs_rom_n_d;
      cs_ram_n_q <= cs_ram_n_d;
    end
  end

  assign done0    = done0_q;
  assign done1    = done1_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_rom_n = cs_rom_n_q;
  assign cs_ram_n = cs_ram_n_q;

endmodule
